// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop cell with synchronous clear
module tff_cell (
    input  logic clk,
    input  logic clr,
    input  logic t,
    output logic q
);

    // Toggle on T, clear has priority over any toggle request
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_modn_counter.sv
// rtl/tff_modn_counter.sv - mod-N up/down counter built from T flip-flop cells
module tff_modn_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam int MAXV = MODULUS - 1;

    // One extra bit so MODULUS == 2**WIDTH still fits in the comparisons
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   MAXV_EXT = (WIDTH + 1)'(MAXV);
    localparam logic [WIDTH-1:0] MAXV_Q   = WIDTH'(MAXV);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
            $error("tff_modn_counter: WIDTH must be 1..16 and MODULUS 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   q_inc;
    logic [WIDTH:0]   q_dec;
    logic             wrap_step;
    logic             bad_load;

    assign q_ext = {1'b0, q};
    assign d_ext = {1'b0, d};
    assign q_inc = q_ext + 1'b1;
    assign q_dec = q_ext - 1'b1;

    // Next count: load beats count; out-of-range states behave as a wrap
    always_comb begin
        next_q    = q;
        wrap_step = 1'b0;
        bad_load  = 1'b0;
        if (load) begin
            if (d_ext < MOD_EXT) begin
                next_q = d;
            end else begin
                next_q   = MAXV_Q;
                bad_load = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q_ext >= MAXV_EXT) begin
                    next_q    = '0;
                    wrap_step = 1'b1;
                end else begin
                    next_q = q_inc[WIDTH-1:0];
                end
            end else begin
                if (q_ext == '0 || q_ext > MAXV_EXT) begin
                    next_q    = MAXV_Q;
                    wrap_step = 1'b1;
                end else begin
                    next_q = q_dec[WIDTH-1:0];
                end
            end
        end
    end

    // Only bits that differ from the next count are toggled
    assign t  = q ^ next_q;

    assign tc = en & ~load & (up ? (q_ext == MAXV_EXT) : (q_ext == '0));

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            tff_cell u_cell (
                .clk (clk),
                .clr (clr),
                .t   (t[i]),
                .q   (q[i])
            );
        end
    endgenerate

    // Status pulses land on the same edge as the count they describe
    always_ff @(posedge clk) begin
        if (clr) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_step;
            load_err <= bad_load;
        end
    end

endmodule

// File: tb/tb_tff_modn_counter.sv
// tb/tb_tff_modn_counter.sv - scoreboard bench for tff_modn_counter
module tb_tff_modn_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       clr, en, up, load;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc, wrap, load_err;

    logic       clr16, en16, up16, load16;
    logic [3:0] d16;
    logic [3:0] q16;
    logic       tc16, wrap16, err16;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       tc;
        logic [3:0] q;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   m_q = 0;

    always #5 clk = ~clk;

    tff_modn_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
        .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    tff_modn_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .clr(clr16), .en(en16), .up(up16), .load(load16), .d(d16),
        .q(q16), .tc(tc16), .wrap(wrap16), .load_err(err16)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic l, input logic e, input logic u, input int dv);
        exp_t it;
        int   nq;
        logic w;
        logic er;
        @(negedge clk);
        clr  = c;
        load = l;
        en   = e;
        up   = u;
        d    = 4'(dv);
        it.tc = e && !l && (u ? (m_q == M - 1) : (m_q == 0));
        nq = m_q;
        w  = 1'b0;
        er = 1'b0;
        if (c) begin
            nq = 0;
        end else if (l) begin
            if (dv < M) nq = dv;
            else begin
                nq = M - 1;
                er = 1'b1;
            end
        end else if (e) begin
            if (u) begin
                nq = (m_q + 1) % M;
                w  = (m_q == M - 1);
            end else begin
                nq = (m_q + M - 1) % M;
                w  = (m_q == 0);
            end
        end
        it.q    = 4'(nq);
        it.wrap = w;
        it.err  = er;
        m_q     = nq;
        sb.push_back(it);
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                chk("tc", int'(tc), int'(it.tc));
                @(posedge clk);
                #1;
                chk("q", int'(q), int'(it.q));
                chk("wrap", int'(wrap), int'(it.wrap));
                chk("load_err", int'(load_err), int'(it.err));
            end
        end
    end

    initial begin : driver
        clr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; d = '0;
        clr16 = 1'b1; load16 = 1'b0; en16 = 1'b0; up16 = 1'b1; d16 = '0;

        // reset with competing load and count
        step(1, 1, 1, 1, 7);
        step(1, 1, 1, 1, 7);
        // up count through the wrap
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
        // down count through the wrap
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        // out-of-range load clamps and flags, then a clean load
        step(0, 1, 1, 1, 12);
        step(0, 1, 0, 0, 3);
        // clr beats load
        step(0, 1, 0, 0, 6);
        step(1, 1, 0, 0, 5);
        // hold
        step(0, 1, 0, 0, 4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom),
                 int'($urandom_range(0, 15)));
        end

        // full-range instance: 15 -> 0 toggles every cell
        @(negedge clk);
        clr16 = 1'b0; load16 = 1'b1; d16 = 4'd15;
        @(negedge clk);
        load16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
        #1;
        chk("q16_pre", int'(q16), 15);
        chk("tc16", int'(tc16), 1);
        chk("t16_all", int'(dut16.t), 15);
        @(posedge clk);
        #1;
        chk("q16_wrap", int'(q16), 0);
        chk("wrap16", int'(wrap16), 1);
        en16 = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
